// File: rtl/pad_in_filter.sv
// Pad input conditioning: 2-flop synchroniser, per-pad stability filter,
// and registered rise/fall edge pulses toward the cio_*_i inputs.
module pad_in_filter #(
  parameter int               NPads        = 66,
  parameter int               FilterCycles = 4,
  parameter logic [NPads-1:0] ResetVal     = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NPads-1:0] pad_in_i,
  input  logic [NPads-1:0] filter_en_i,
  output logic [NPads-1:0] pad_in_o,
  output logic [NPads-1:0] rise_o,
  output logic [NPads-1:0] fall_o
);

  localparam int CntW = $clog2(FilterCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(FilterCycles - 1);

  if (FilterCycles < 1) begin : g_bad_cfg
    $error("FilterCycles must be >= 1");
  end

  logic [NPads-1:0] sync1_q;
  logic [NPads-1:0] sync2_q;
  logic [NPads-1:0] v_q, v_d;
  logic [NPads-1:0] rise_q, rise_d;
  logic [NPads-1:0] fall_q, fall_d;
  logic [CntW-1:0]  cnt_q [NPads];
  logic [CntW-1:0]  cnt_d [NPads];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= ResetVal;
      sync2_q <= ResetVal;
    end else begin
      sync1_q <= pad_in_i;
      sync2_q <= sync1_q;
    end
  end

  // A mismatch must persist FilterCycles edges; any match restarts the count.
  always_comb begin
    v_d = v_q;
    for (int i = 0; i < NPads; i++) begin
      cnt_d[i] = '0;
      if (!filter_en_i[i]) begin
        v_d[i] = sync2_q[i];
      end else if (sync2_q[i] != v_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          v_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
    rise_d = v_d & ~v_q;
    fall_d = ~v_d & v_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q    <= ResetVal;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < NPads; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < NPads; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign pad_in_o = v_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

  a_no_dual_edge : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (rise_o & fall_o) == '0);

  a_known_out : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({pad_in_o, rise_o, fall_o}));

endmodule

// File: tb/tb_pad_in_filter.sv
// Directed checks of pad_in_filter latency, glitch rejection and edges,
// followed by random toggling against a sliding-window reference.
module tb_pad_in_filter;

  localparam int N  = 66;
  localparam int FC = 4;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] pad;
  logic [N-1:0] en;
  logic [N-1:0] pad_o;
  logic [N-1:0] rise;
  logic [N-1:0] fall;

  int n_vec;
  int n_err;

  pad_in_filter #(
    .NPads       (N),
    .FilterCycles(FC),
    .ResetVal    ('0)
  ) u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .pad_in_i   (pad),
    .filter_en_i(en),
    .pad_in_o   (pad_o),
    .rise_o     (rise),
    .fall_o     (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: accept when the current and previous FC-1 synced samples
  // all differ from the held level.
  logic [N-1:0] m_s1, m_s2, h0, h1, h2;
  logic [N-1:0] m_v, m_vd, m_mis, m_r, m_f;

  always_comb begin
    m_mis = (m_s2 ^ m_v) & (h0 ^ m_v) & (h1 ^ m_v) & (h2 ^ m_v);
    m_vd  = (~en & m_s2)
          | (en & ((m_mis & m_s2) | (~m_mis & m_v)));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s1 <= '0; m_s2 <= '0;
      h0   <= '0; h1   <= '0; h2 <= '0;
      m_v  <= '0; m_r  <= '0; m_f <= '0;
    end else begin
      m_s1 <= pad;
      m_s2 <= m_s1;
      h0   <= m_s2;
      h1   <= h0;
      h2   <= h1;
      m_v  <= m_vd;
      m_r  <= m_vd & ~m_v;
      m_f  <= ~m_vd & m_v;
    end
  end

  task automatic check_vec(input string tag,
                           input logic [N-1:0] obs,
                           input logic [N-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] lane(input int i);
    return N'(1) << i;
  endfunction

  function automatic logic p3(input int j);
    if (j < 1 || j > 8) return 1'b0;
    return (((j - 1) / 2) % 2) == 0;
  endfunction

  function automatic logic [N-1:0] bit1(input logic b);
    return N'(b);
  endfunction

  logic [N-1:0] rnd;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    pad   = '0;
    en    = '1;

    // Reset state and lane 32 filtered latency
    repeat (3) @(posedge clk);
    #1;
    check_vec("rst_out",  pad_o, '0);
    check_vec("rst_rise", rise,  '0);
    check_vec("rst_fall", fall,  '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) pad[32] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      check_vec("t1_out",  pad_o, e >= 6 ? lane(32) : '0);
      check_vec("t1_rise", rise,  e == 6 ? lane(32) : '0);
      check_vec("t1_fall", fall,  '0);
    end

    // Lane 59: 3-cycle glitch rejected
    @(negedge clk) pad[59] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk); #1;
      check_vec("t2g_out",  bit1(pad_o[59]), '0);
      check_vec("t2g_rise", rise, '0);
      check_vec("t2g_fall", fall, '0);
      if (e == 3) @(negedge clk) pad[59] = 1'b0;
    end

    // Lane 59: 4-cycle pulse accepted, fall four edges after rise
    @(negedge clk) pad[59] = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      check_vec("t2p_out",  bit1(pad_o[59]), bit1(e >= 6 && e <= 9));
      check_vec("t2p_rise", rise, e == 6  ? lane(59) : '0);
      check_vec("t2p_fall", fall, e == 10 ? lane(59) : '0);
      if (e == 4) @(negedge clk) pad[59] = 1'b0;
    end

    // Lane 40 unfiltered, toggle every 2 cycles
    @(negedge clk) en[40] = 1'b0;
    repeat (2) @(posedge clk);
    for (int j = 1; j <= 12; j++) begin
      @(negedge clk) pad[40] = p3(j);
      @(posedge clk); #1;
      check_vec("t3_out",  bit1(pad_o[40]), bit1(p3(j - 2)));
      check_vec("t3_rise", rise,
                (p3(j - 2) & ~p3(j - 3)) ? lane(40) : '0);
      check_vec("t3_fall", fall,
                (~p3(j - 2) & p3(j - 3)) ? lane(40) : '0);
    end

    // Lane 61: disable filter mid-count, then re-enable
    @(negedge clk) pad[61] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      check_vec("t4_cnt_out",  bit1(pad_o[61]), '0);
      check_vec("t4_cnt_rise", rise, '0);
    end
    @(negedge clk) en[61] = 1'b0;
    @(posedge clk); #1;
    check_vec("t4_off_out",  bit1(pad_o[61]), N'(1));
    check_vec("t4_off_rise", rise, lane(61));
    check_vec("t4_off_fall", fall, '0);
    @(negedge clk) en[61] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); #1;
      check_vec("t4_on_out",  bit1(pad_o[61]), N'(1));
      check_vec("t4_on_rise", rise, '0);
      check_vec("t4_on_fall", fall, '0);
    end

    // Lane 33: async reset mid-count, release with pad held high
    @(negedge clk) begin
      pad = '0;
      en  = '1;
    end
    repeat (12) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) pad[33] = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_vec("t5_rst_out",  pad_o, '0);
    check_vec("t5_rst_rise", rise,  '0);
    check_vec("t5_rst_fall", fall,  '0);
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clk); #1;
      check_vec("t5_out",  pad_o, e >= 6 ? lane(33) : '0);
      check_vec("t5_rise", rise,  e == 6 ? lane(33) : '0);
      check_vec("t5_fall", fall,  '0);
    end

    // All lanes random toggling with random filter enables
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(5) == 0) pad[i] = ~pad[i];
      end
      if (c % 64 == 0) begin
        rnd = {$urandom, $urandom, $urandom};
        en  = rnd;
      end
      @(posedge clk); #1;
      check_vec("t6_out",  pad_o, m_v);
      check_vec("t6_rise", rise,  m_r);
      check_vec("t6_fall", fall,  m_f);
      check_vec("t6_both", rise & fall, '0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
